// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encodings, parity modes and helpers
package uart_pkg;

  // Receiver/transmitter frame states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4
  } uart_state_e;

  // Parity modes selected by the PARITY parameter.
  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Oversample ticks per data/parity bit.
  localparam int OVERSAMPLE = 16;

  // Parity error for a word (given as its XOR reduction) and its parity bit.
  function automatic logic parity_error(input logic data_xor, input logic par_bit,
                                        input int mode);
    logic mismatch;
    mismatch = data_xor ^ par_bit;
    case (mode)
      PARITY_EVEN: return mismatch;
      PARITY_ODD:  return ~mismatch;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - rx synchronizer and start-bit detector
module uart_rx_sync (
  input  logic clk_50MHz,
  input  logic reset,
  input  logic rx,
  input  logic disarm,
  output logic rx_s,
  output logic start_det
);

  logic rx_meta_q, rx_meta_d;
  logic rx_s_q, rx_s_d;
  logic armed_q, armed_d;

  // Two-stage synchronizer; armed drops after a frame error and comes back
  // only once the synchronized line has been seen high again.
  always_comb begin
    rx_meta_d = rx;
    rx_s_d    = rx_meta_q;
    armed_d   = armed_q;
    if (disarm) begin
      armed_d = 1'b0;
    end else if (rx_s_q) begin
      armed_d = 1'b1;
    end
  end

  // State registers; the synchronizer resets to the idle-high line level.
  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      armed_q   <= 1'b1;
    end else begin
      rx_meta_q <= rx_meta_d;
      rx_s_q    <= rx_s_d;
      armed_q   <= armed_d;
    end
  end

  assign rx_s      = rx_s_q;
  assign start_det = armed_q & ~rx_s_q;

endmodule

// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - configurable oversampling UART receiver with status flags
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_BITS     = 8,
  parameter int STOP_BIT_TICK = 16,
  parameter int PARITY        = 0,
  parameter int MSB_FIRST     = 1
) (
  input  logic                 clk_50MHz,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 sample_tick,
  input  logic                 read_ack,
  output logic                 data_ready,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 overrun
);

  localparam logic [4:0] START_MID = 5'd7;
  localparam logic [4:0] BIT_LAST  = 5'(OVERSAMPLE - 1);
  localparam logic [4:0] STOP_LAST = 5'(STOP_BIT_TICK - 1);
  localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);

  logic rx_s;
  logic start_det;
  logic disarm;

  uart_state_e          state_q, state_d;
  logic [4:0]           tick_q, tick_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_bit_q, par_bit_d;
  logic                 stop_bit_q, stop_bit_d;
  logic                 done_q, done_d;

  logic [DATA_BITS-1:0] data_out_q, data_out_d;
  logic                 data_ready_q, data_ready_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 break_det_q, break_det_d;
  logic                 overrun_q, overrun_d;

  logic word_par_err;
  logic word_frame_err;
  logic word_break;
  logic ack;

  uart_rx_sync u_sync (
    .clk_50MHz (clk_50MHz),
    .reset     (reset),
    .rx        (rx),
    .disarm    (disarm),
    .rx_s      (rx_s),
    .start_det (start_det)
  );

  // Frame FSM: tick counting, mid-bit sampling and end-of-frame strobe.
  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    par_bit_d  = par_bit_q;
    stop_bit_d = stop_bit_q;
    done_d     = 1'b0;
    disarm     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_det) begin
          state_d = ST_START;
          tick_d  = '0;
        end
      end
      ST_START: begin
        if (sample_tick) begin
          if (tick_q == START_MID) begin
            tick_d = '0;
            if (rx_s) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_DATA;
              bit_d   = '0;
            end
          end else begin
            tick_d = tick_q + 5'd1;
          end
        end
      end
      ST_DATA: begin
        if (sample_tick) begin
          if (tick_q == BIT_LAST) begin
            tick_d = '0;
            if (MSB_FIRST != 0) begin
              shift_d = {shift_q[DATA_BITS-2:0], rx_s};
            end else begin
              shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
            end
            if (bit_q == LAST_BIT) begin
              bit_d   = '0;
              state_d = (PARITY != PARITY_NONE) ? ST_PAR : ST_STOP;
            end else begin
              bit_d = bit_q + 4'd1;
            end
          end else begin
            tick_d = tick_q + 5'd1;
          end
        end
      end
      ST_PAR: begin
        if (sample_tick) begin
          if (tick_q == BIT_LAST) begin
            tick_d    = '0;
            par_bit_d = rx_s;
            state_d   = ST_STOP;
          end else begin
            tick_d = tick_q + 5'd1;
          end
        end
      end
      ST_STOP: begin
        if (sample_tick) begin
          if (tick_q == STOP_LAST) begin
            tick_d     = '0;
            stop_bit_d = rx_s;
            done_d     = 1'b1;
            disarm     = ~rx_s;
            state_d    = ST_IDLE;
          end else begin
            tick_d = tick_q + 5'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output register: loads the finished word one clock after the stop sample,
  // tracks the unread flag and the sticky overrun.
  always_comb begin
    word_par_err   = parity_error(^shift_q, par_bit_q, PARITY);
    word_frame_err = ~stop_bit_q;
    word_break     = word_frame_err & (shift_q == '0) &
                     ((PARITY == PARITY_NONE) | ~par_bit_q);
    ack            = read_ack & data_ready_q;

    data_out_d   = data_out_q;
    data_ready_d = data_ready_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    break_det_d  = break_det_q;
    overrun_d    = overrun_q;

    if (done_q) begin
      data_out_d   = shift_q;
      parity_err_d = word_par_err;
      frame_err_d  = word_frame_err;
      break_det_d  = word_break;
      data_ready_d = 1'b1;
      // A simultaneous read consumes the old word, so it is not an overrun.
      if (data_ready_q && !read_ack) begin
        overrun_d = 1'b1;
      end else if (ack) begin
        overrun_d = 1'b0;
      end
    end else if (ack) begin
      data_ready_d = 1'b0;
      overrun_d    = 1'b0;
    end
  end

  // All receiver state registers.
  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      tick_q       <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      par_bit_q    <= 1'b0;
      stop_bit_q   <= 1'b1;
      done_q       <= 1'b0;
      data_out_q   <= '0;
      data_ready_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      break_det_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_q       <= tick_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      par_bit_q    <= par_bit_d;
      stop_bit_q   <= stop_bit_d;
      done_q       <= done_d;
      data_out_q   <= data_out_d;
      data_ready_q <= data_ready_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      break_det_q  <= break_det_d;
      overrun_q    <= overrun_d;
    end
  end

  assign data_ready = data_ready_q;
  assign data_out   = data_out_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign break_det  = break_det_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb/tb_uart_rx_cfg.sv - self-checking bench for uart_rx_cfg in three configurations
module tb_uart_rx_cfg;

  logic       clk_50MHz   = 1'b0;
  logic       reset       = 1'b1;
  logic       sample_tick = 1'b0;
  logic [2:0] rx_line     = 3'b111;
  logic [2:0] read_ack    = 3'b000;
  logic [2:0] ready, pe, fe, bd, ov;
  logic [7:0] dout_a, dout_b;
  logic [6:0] dout_c;
  int tick_div = 0;
  int cyc      = 0;
  int checks   = 0;
  int errors   = 0;

  // Per-instance configuration: data bits, parity mode, msb-first, stop ticks.
  localparam int NB  [3] = '{8, 8, 7};
  localparam int PM  [3] = '{0, 1, 2};
  localparam int MSB [3] = '{1, 1, 0};
  localparam int STK [3] = '{16, 16, 32};

  // Reference model of each receiver's visible output register.
  logic [2:0] exp_ready, exp_pe, exp_fe, exp_bd, exp_ov;
  logic [8:0] exp_data [3];

  always #10 clk_50MHz = ~clk_50MHz;

  // Shared 16x tick: one pulse every 4 clocks.
  always @(posedge clk_50MHz) begin
    cyc         <= cyc + 1;
    tick_div    <= (tick_div == 3) ? 0 : tick_div + 1;
    sample_tick <= (tick_div == 3);
  end

  uart_rx_cfg #(.DATA_BITS(8), .STOP_BIT_TICK(16), .PARITY(0), .MSB_FIRST(1)) dut_a (
    .clk_50MHz(clk_50MHz), .reset(reset), .rx(rx_line[0]), .sample_tick(sample_tick),
    .read_ack(read_ack[0]), .data_ready(ready[0]), .data_out(dout_a),
    .parity_err(pe[0]), .frame_err(fe[0]), .break_det(bd[0]), .overrun(ov[0]));

  uart_rx_cfg #(.DATA_BITS(8), .STOP_BIT_TICK(16), .PARITY(1), .MSB_FIRST(1)) dut_b (
    .clk_50MHz(clk_50MHz), .reset(reset), .rx(rx_line[1]), .sample_tick(sample_tick),
    .read_ack(read_ack[1]), .data_ready(ready[1]), .data_out(dout_b),
    .parity_err(pe[1]), .frame_err(fe[1]), .break_det(bd[1]), .overrun(ov[1]));

  uart_rx_cfg #(.DATA_BITS(7), .STOP_BIT_TICK(32), .PARITY(2), .MSB_FIRST(0)) dut_c (
    .clk_50MHz(clk_50MHz), .reset(reset), .rx(rx_line[2]), .sample_tick(sample_tick),
    .read_ack(read_ack[2]), .data_ready(ready[2]), .data_out(dout_c),
    .parity_err(pe[2]), .frame_err(fe[2]), .break_det(bd[2]), .overrun(ov[2]));

  function automatic logic [8:0] obs_data(input int i);
    case (i)
      0:       return {1'b0, dout_a};
      1:       return {1'b0, dout_b};
      default: return {2'b0, dout_c};
    endcase
  endfunction

  function automatic logic [4:0] obs_flags(input int i);
    return {ready[i], pe[i], fe[i], bd[i], ov[i]};
  endfunction

  function automatic logic [4:0] exp_flags(input int i);
    return {exp_ready[i], exp_pe[i], exp_fe[i], exp_bd[i], exp_ov[i]};
  endfunction

  function automatic logic [8:0] mask_of(input int i);
    return 9'((1 << NB[i]) - 1);
  endfunction

  // Line parity bit the transmitter sends; bad flips it.
  function automatic logic par_bit_for(input int i, input logic [8:0] w, input bit bad);
    logic x;
    x = ^(w & mask_of(i));
    if (PM[i] == 2) x = ~x;
    return x ^ bad;
  endfunction

  task automatic wait_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      do @(negedge clk_50MHz); while (!sample_tick);
    end
  endtask

  // Serialize one frame onto rx_line[i] in instance i's format.
  task automatic send_frame(input int i, input logic [8:0] w, input bit bad, input bit stop_v);
    logic [8:0] m;
    m = w & mask_of(i);
    wait_ticks(1);
    rx_line[i] = 1'b0;
    wait_ticks(16);
    for (int b = 0; b < NB[i]; b++) begin
      rx_line[i] = (MSB[i] != 0) ? m[NB[i]-1-b] : m[b];
      wait_ticks(16);
    end
    if (PM[i] != 0) begin
      rx_line[i] = par_bit_for(i, m, bad);
      wait_ticks(16);
    end
    rx_line[i] = stop_v;
    wait_ticks(STK[i]);
    rx_line[i] = 1'b1;
  endtask

  task automatic model_frame(input int i, input logic [8:0] w, input bit bad,
                             input bit stop_v, input bit acked);
    logic [8:0] m;
    m = w & mask_of(i);
    exp_ov[i]    = acked ? 1'b0 : (exp_ready[i] ? 1'b1 : exp_ov[i]);
    exp_ready[i] = 1'b1;
    exp_data[i]  = m;
    exp_pe[i]    = (PM[i] != 0) && bad;
    exp_fe[i]    = !stop_v;
    exp_bd[i]    = !stop_v && (m == 9'h0) && (PM[i] == 0 || !par_bit_for(i, m, bad));
  endtask

  task automatic do_ack(input int i);
    read_ack[i] = 1'b1;
    @(negedge clk_50MHz);
    read_ack[i] = 1'b0;
    if (exp_ready[i]) begin
      exp_ready[i] = 1'b0;
      exp_ov[i]    = 1'b0;
    end
  endtask

  task automatic test_reset;
    exp_ready = '0; exp_pe = '0; exp_fe = '0; exp_bd = '0; exp_ov = '0;
    for (int i = 0; i < 3; i++) exp_data[i] = '0;
    reset = 1'b1;
    repeat (5) @(negedge clk_50MHz);
    reset = 1'b0;
    repeat (3) @(negedge clk_50MHz);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs_flags(i) !== 5'b0 || obs_data(i) !== 9'h0) begin
        errors++;
        $display("FAIL reset dut%0d flags=%b data=%h want 00000 000", i, obs_flags(i), obs_data(i));
      end
    end
  endtask

  task automatic test_basic;
    send_frame(0, 9'h041, 1'b0, 1'b1);
    model_frame(0, 9'h041, 1'b0, 1'b1, 1'b0);
    repeat (3) @(negedge clk_50MHz);
    checks++;
    if (obs_flags(0) !== exp_flags(0) || obs_data(0) !== exp_data[0]) begin
      errors++;
      $display("FAIL basic_0x41 flags=%b data=%h want %b %h", obs_flags(0), obs_data(0), exp_flags(0), exp_data[0]);
    end
    do_ack(0);
    @(negedge clk_50MHz);
    checks++;
    if (obs_flags(0) !== exp_flags(0)) begin
      errors++;
      $display("FAIL basic_ack flags=%b want %b", obs_flags(0), exp_flags(0));
    end
  endtask

  task automatic test_parity;
    logic [8:0] w;
    bit bad;
    for (int n = 0; n < 6; n++) begin
      int i;
      i   = (n < 2) ? 1 : 2;
      w   = (n < 2) ? 9'h043 : 9'($urandom);
      bad = (n < 2) ? (n == 0) : ($urandom_range(0, 1) == 1);
      send_frame(i, w, bad, 1'b1);
      model_frame(i, w, bad, 1'b1, 1'b0);
      repeat (3) @(negedge clk_50MHz);
      checks++;
      if (obs_flags(i) !== exp_flags(i) || obs_data(i) !== exp_data[i]) begin
        errors++;
        $display("FAIL parity dut%0d bad=%0d flags=%b data=%h want %b %h", i, bad,
                 obs_flags(i), obs_data(i), exp_flags(i), exp_data[i]);
      end
      do_ack(i);
    end
  endtask

  task automatic test_overrun;
    read_ack[0] = 1'b1;
    repeat (2) @(negedge clk_50MHz);
    read_ack[0] = 1'b0;
    send_frame(0, 9'h042, 1'b0, 1'b1);
    model_frame(0, 9'h042, 1'b0, 1'b1, 1'b0);
    send_frame(0, 9'h043, 1'b0, 1'b1);
    model_frame(0, 9'h043, 1'b0, 1'b1, 1'b0);
    repeat (3) @(negedge clk_50MHz);
    checks++;
    if (obs_flags(0) !== exp_flags(0) || obs_data(0) !== exp_data[0]) begin
      errors++;
      $display("FAIL overrun_set flags=%b data=%h want %b %h", obs_flags(0), obs_data(0), exp_flags(0), exp_data[0]);
    end
    do_ack(0);
    @(negedge clk_50MHz);
    checks++;
    if (obs_flags(0) !== exp_flags(0)) begin
      errors++;
      $display("FAIL overrun_clear flags=%b want %b", obs_flags(0), exp_flags(0));
    end
  endtask

  task automatic test_ack_collision;
    logic [8:0] w1, w2;
    int t0, rise, lat;
    w1 = 9'($urandom_range(1, 127));
    w2 = w1 | 9'h080;
    rise = -1;
    wait_ticks(1);
    t0 = cyc;
    fork
      send_frame(0, w1, 1'b0, 1'b1);
      begin
        for (int k = 0; k < 3000 && rise < 0; k++) begin
          @(negedge clk_50MHz);
          if (ready[0]) rise = cyc;
        end
      end
    join
    model_frame(0, w1, 1'b0, 1'b1, 1'b0);
    checks++;
    if (rise < 0) begin
      errors++;
      $display("FAIL collision_latency data_ready never rose within 3000 cycles");
    end
    lat = rise - t0;
    repeat (3) @(negedge clk_50MHz);
    wait_ticks(1);
    t0 = cyc;
    fork
      send_frame(0, w2, 1'b0, 1'b1);
      begin
        if (rise >= 0) begin
          while (cyc < t0 + lat - 1) @(negedge clk_50MHz);
          read_ack[0] = 1'b1;
          @(negedge clk_50MHz);
          read_ack[0] = 1'b0;
        end
      end
    join
    model_frame(0, w2, 1'b0, 1'b1, 1'b1);
    repeat (3) @(negedge clk_50MHz);
    checks++;
    if (obs_flags(0) !== exp_flags(0) || obs_data(0) !== exp_data[0]) begin
      errors++;
      $display("FAIL collision flags=%b data=%h want %b %h", obs_flags(0), obs_data(0), exp_flags(0), exp_data[0]);
    end
    do_ack(0);
  endtask

  task automatic test_glitch;
    wait_ticks(1);
    rx_line[0] = 1'b0;
    wait_ticks(3);
    rx_line[0] = 1'b1;
    wait_ticks(20);
    checks++;
    if (obs_flags(0) !== exp_flags(0)) begin
      errors++;
      $display("FAIL glitch_ignored flags=%b want %b", obs_flags(0), exp_flags(0));
    end
    send_frame(0, 9'h055, 1'b0, 1'b1);
    model_frame(0, 9'h055, 1'b0, 1'b1, 1'b0);
    repeat (3) @(negedge clk_50MHz);
    checks++;
    if (obs_flags(0) !== exp_flags(0) || obs_data(0) !== exp_data[0]) begin
      errors++;
      $display("FAIL glitch_then_0x55 flags=%b data=%h want %b %h", obs_flags(0), obs_data(0), exp_flags(0), exp_data[0]);
    end
    do_ack(0);
  endtask

  task automatic test_break;
    wait_ticks(1);
    rx_line[0] = 1'b0;
    wait_ticks(16 * 11);
    model_frame(0, 9'h000, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs_flags(0) !== exp_flags(0) || obs_data(0) !== exp_data[0]) begin
      errors++;
      $display("FAIL break_word flags=%b data=%h want %b %h", obs_flags(0), obs_data(0), exp_flags(0), exp_data[0]);
    end
    do_ack(0);
    wait_ticks(16 * 13);
    checks++;
    if (obs_flags(0) !== exp_flags(0)) begin
      errors++;
      $display("FAIL break_no_rearm flags=%b want %b", obs_flags(0), exp_flags(0));
    end
    rx_line[0] = 1'b1;
    wait_ticks(32);
    send_frame(0, 9'h041, 1'b0, 1'b1);
    model_frame(0, 9'h041, 1'b0, 1'b1, 1'b0);
    repeat (3) @(negedge clk_50MHz);
    checks++;
    if (obs_flags(0) !== exp_flags(0) || obs_data(0) !== exp_data[0]) begin
      errors++;
      $display("FAIL break_recover flags=%b data=%h want %b %h", obs_flags(0), obs_data(0), exp_flags(0), exp_data[0]);
    end
    do_ack(0);
  endtask

  task automatic test_reset_midframe;
    logic [8:0] w;
    w = 9'($urandom_range(1, 255));
    send_frame(1, w, 1'b0, 1'b1);
    model_frame(1, w, 1'b0, 1'b1, 1'b0);
    fork
      send_frame(0, 9'h0A5, 1'b0, 1'b1);
      begin
        wait_ticks(1 + 16 * 5 + 8);
        reset = 1'b1;
        repeat (2) @(negedge clk_50MHz);
        for (int i = 0; i < 3; i++) begin
          checks++;
          if (obs_flags(i) !== 5'b0 || obs_data(i) !== 9'h0) begin
            errors++;
            $display("FAIL reset_mid dut%0d flags=%b data=%h want 00000 000", i, obs_flags(i), obs_data(i));
          end
        end
      end
    join
    repeat (4) @(negedge clk_50MHz);
    reset = 1'b0;
    exp_ready = '0; exp_pe = '0; exp_fe = '0; exp_bd = '0; exp_ov = '0;
    for (int i = 0; i < 3; i++) exp_data[i] = '0;
    repeat (20) @(negedge clk_50MHz);
    checks++;
    if (ready !== 3'b000) begin
      errors++;
      $display("FAIL reset_no_ready data_ready=%b want 000", ready);
    end
    for (int n = 0; n < 2; n++) begin
      int i;
      i = (n == 0) ? 0 : 2;
      send_frame(i, 9'h05A, 1'b0, 1'b1);
      model_frame(i, 9'h05A, 1'b0, 1'b1, 1'b0);
      repeat (3) @(negedge clk_50MHz);
      checks++;
      if (obs_flags(i) !== exp_flags(i) || obs_data(i) !== exp_data[i]) begin
        errors++;
        $display("FAIL reset_then_0x5A dut%0d flags=%b data=%h want %b %h", i,
                 obs_flags(i), obs_data(i), exp_flags(i), exp_data[i]);
      end
      do_ack(i);
    end
  endtask

  task automatic test_back_to_back;
    logic [8:0] w;
    bit bad, stop_v;
    int i;
    for (int n = 0; n < 14; n++) begin
      i      = int'($urandom_range(0, 2));
      w      = 9'($urandom);
      bad    = (PM[i] != 0) && ($urandom_range(0, 3) == 0);
      stop_v = ($urandom_range(0, 5) != 0);
      send_frame(i, w, bad, stop_v);
      model_frame(i, w, bad, stop_v, 1'b0);
      repeat (3) @(negedge clk_50MHz);
      checks++;
      if (obs_flags(i) !== exp_flags(i) || obs_data(i) !== exp_data[i]) begin
        errors++;
        $display("FAIL b2b[%0d] dut%0d flags=%b data=%h want %b %h", n, i,
                 obs_flags(i), obs_data(i), exp_flags(i), exp_data[i]);
      end
      if ($urandom_range(0, 1) == 1) do_ack(i);
      wait_ticks(int'($urandom_range(0, 2)) + (stop_v ? 0 : 2));
    end
  endtask

  initial begin
    #(20 * 150000);
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_overrun();
    test_ack_collision();
    test_glitch();
    test_break();
    test_reset_midframe();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame; legal range 5..9.
REQ-002 SHALL have parameter STOP_BIT_TICK, default 16, meaning oversample ticks per stop bit; legal values 16 or 32.
REQ-003 SHALL have parameter PARITY, default 0, meaning 0 none, 1 even, 2 odd.
REQ-004 SHALL have parameter MSB_FIRST, default 1, meaning 1 = first data bit on the line is data_out[DATA_BITS-1], 0 = LSB first.
REQ-005 SHALL have port clk_50MHz, input, 1 bit: the single clock.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port rx, input, 1 bit: asynchronous serial line, idle high.
REQ-008 SHALL have port sample_tick, input, 1 bit: one-cycle pulse at 16x baud from the external baud_rate_generator.
REQ-009 SHALL have port data_ready, output, 1 bit: data_out holds an unread byte.
REQ-010 SHALL have port read_ack, input, 1 bit: consumer accepts data_out this cycle.
REQ-011 SHALL have port data_out, output, DATA_BITS bits: received word.
REQ-012 SHALL have ports parity_err, frame_err, break_det and overrun, each output, 1 bit: status for the word in data_out; overrun is sticky.

Function
REQ-013 SHALL pass rx through a 2-flop synchronizer; all decisions use the synchronized value rx_s.
REQ-014 SHALL implement states IDLE, START, DATA, PAR, STOP; a tick counter advances only on sample_tick.
REQ-015 IDLE -> START on the first cycle rx_s is 0; tick counter cleared.
REQ-016 START: at tick count 7, if rx_s = 1 (glitch), return to IDLE with no output; otherwise clear the counter and go to DATA.
REQ-017 DATA: sample rx_s every 16th tick, DATA_BITS times, shifting in the MSB_FIRST order; then go to PAR if PARITY != 0, else STOP.
REQ-018 PAR: sample one bit after 16 ticks; parity_err = (XOR of data bits XOR sampled bit) != 0 for even, and the complement of that for odd.
REQ-019 STOP: sample after STOP_BIT_TICK ticks; frame_err = (sample == 0); break_det = frame_err AND all data bits 0 AND (parity bit 0 if PARITY != 0).
REQ-020 On the stop sample, the word and its flags SHALL load into the output register one clock later, with data_ready set in that same cycle; the FSM then returns to IDLE.
REQ-021 data_ready SHALL stay high until read_ack is sampled high; read_ack while data_ready is low SHALL be ignored.
REQ-022 Completion of a new word while data_ready = 1 and read_ack = 0 SHALL overwrite data_out and its flags, keep data_ready = 1, and set overrun.
REQ-023 If a word completes in the same cycle as read_ack, the new word SHALL load, data_ready SHALL remain 1, and overrun SHALL NOT set.
REQ-024 overrun SHALL clear only on a read_ack that finds data_ready = 1.
REQ-025 On a frame error the FSM SHALL return to IDLE and wait for rx_s = 1 before accepting a new start bit.

Reset
REQ-026 While reset is high on a clk_50MHz edge: state = IDLE; counters = 0; synchronizer flops = 1; data_out = 0; data_ready, parity_err, frame_err, break_det and overrun = 0.
REQ-027 Reset mid-frame SHALL abandon the frame with no data_ready pulse; reception resumes at the next falling edge after reset is released.

Structure
REQ-028 State encodings and the PARITY mode constants (NONE/EVEN/ODD) SHALL reside in the shared uart package used by the transmitter.
REQ-029 The synchronizer plus start-bit detector SHALL be one sub-module, uart_rx_sync.
REQ-030 The baud_rate_generator SHALL stay external so that several receivers can share one sample_tick.

Verification
REQ-031 DATA_BITS=8, PARITY=0, MSB_FIRST=1, send 0x41 at 9600 baud -> data_ready, data_out=0x41, all flags 0.
REQ-032 PARITY=1, send 0x43 with a wrong parity bit -> data_out=0x43, parity_err=1; with the correct bit -> parity_err=0.
REQ-033 Send 0x42 then 0x43 with no read_ack -> data_out=0x43, overrun=1; read_ack -> data_ready=0 and overrun=0.
REQ-034 Hold rx low for 12 bit times -> data_out=0x00, frame_err=1, break_det=1; no second word until rx returns high.
REQ-035 Drive a 3-tick low glitch on rx -> no data_ready; a following 0x55 is received correctly.
REQ-036 Assert reset during bit 4 of 0xA5 -> all outputs 0, no data_ready; a following 0x5A is received correctly, including with MSB_FIRST=0 and DATA_BITS=7.
